uart_tx_stream: RTL and testbench

Parametrised UART transmitter with a valid/ready input stream and a small transmit FIFO. It replaces fixed-character, button-triggered serial output with arbitrary words from any producer, such as score or paddle-event reporting. Baud rate, word width, stop bits and FIFO depth are set by parameters, and optional parity is added at compile time. It sits between game logic and the board's USB-UART TX pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_tx_stream.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_stream.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states, default clocking and the baud divider helper.
package uart_pkg;

    localparam int CLK_FREQ_DEFAULT  = 65_000_000;
    localparam int BAUD_RATE_DEFAULT = 9_600;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIV-1 and pulses tick on the last count of each bit.
module uart_baud_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx_stream.sv
// UART transmitter fed by a valid/ready stream through a small FIFO.
// Define UART_TX_PARITY_EN to add a parity bit; parity_odd then selects odd (1) or even (0).
module uart_tx_stream
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
    parameter int BAUD_RATE  = BAUD_RATE_DEFAULT,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_BITS-1:0]        tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
`ifdef UART_TX_PARITY_EN
    input  logic                        parity_odd,
`endif
    output logic                        txd,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int DIV   = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL      = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [3:0]     LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]     LAST_STOP = 4'(STOP_BITS - 1);

    uart_tx_state_t state, state_next;

    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [DATA_BITS-1:0] shreg;
    logic [3:0]           bit_cnt;
    logic                 push, pop, shift, cnt_inc, cnt_clr;
    logic                 tick, line_bit;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign tx_ready = (fifo_count != FULL);
    assign push     = tx_valid && tx_ready;
    assign busy     = (state != IDLE) || (fifo_count != '0);

    // Held in clear while idle so the first bit of a frame always gets a full period.
    uart_baud_gen #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (state == IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        shift      = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        line_bit   = 1'b1;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    state_next = START;
                    pop        = 1'b1;
                end
            end
            START: begin
                line_bit = 1'b0;
                if (tick) state_next = DATA;
            end
            DATA: begin
                line_bit = shreg[0];
                if (tick) begin
                    shift = 1'b1;
                    if (bit_cnt == LAST_DATA) begin
                        cnt_clr = 1'b1;
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                line_bit = parity_bit;
                if (tick) state_next = STOP;
            end
`endif
            STOP: begin
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        cnt_clr = 1'b1;
                        // Chain straight into the next start bit when more words wait.
                        if (fifo_count != '0) begin
                            state_next = START;
                            pop        = 1'b1;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            bit_cnt    <= '0;
            txd        <= 1'b1;
        end else begin
            txd <= line_bit;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (cnt_clr) begin
                bit_cnt <= '0;
            end else if (cnt_inc) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Storage and shift data need no reset; txd only exposes them inside a frame.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= tx_data;
        if (pop) begin
            shreg <= fifo_mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^fifo_mem[rd_ptr]) ^ parity_odd;
`endif
        end else if (shift) begin
            shreg <= shreg >> 1;
        end
    end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Directed, table-driven bench for uart_tx_stream at DIV=10; follows UART_TX_PARITY_EN when defined.
module tb_uart_tx_stream;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME_CLKS = (1 + 8 + PBITS + 1) * DIV;

    typedef struct {
        logic [7:0] word;
        logic       par_odd;
        logic       exp_par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;
    logic [6:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2;
    logic       txd2;
    logic       busy2;
    logic [2:0] fifo_count2;
`ifdef UART_TX_PARITY_EN
    logic       parity_odd;
`endif

    int n_vectors     = 0;
    int n_miscompares = 0;
    int cyc           = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_stream #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    uart_tx_stream #(
        .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u_dut2 (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data2),
        .tx_valid   (tx_valid2),
        .tx_ready   (tx_ready2),
`ifdef UART_TX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .txd        (txd2),
        .busy       (busy2),
        .fifo_count (fifo_count2)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Walks one frame bit by bit, checking the first and last clock of every bit window.
    task automatic check_frame(input logic sel, input logic [8:0] word, input int nbits,
                               input int nstop, input logic par_bit, input string tag);
        logic q[$];
        q.push_back(1'b0);
        for (int i = 0; i < nbits; i++) q.push_back(word[i]);
        if (PBITS == 1) q.push_back(par_bit);
        for (int i = 0; i < nstop; i++) q.push_back(1'b1);
        for (int k = 0; k < q.size(); k++) begin
            for (int c = 0; c < DIV; c++) begin
                @(posedge clk); #1;
                if (c == 0 || c == DIV - 1)
                    check_output($sformatf("%s bit%0d clk%0d", tag, k, c),
                                 32'(sel ? txd2 : txd), 32'(q[k]));
            end
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] w, input logic exp_par, input string tag);
        @(negedge clk);
        check_output($sformatf("%s ready", tag), 32'(tx_ready), 32'd1);
        tx_data  = w;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check_output($sformatf("%s count", tag), 32'(fifo_count), 32'd1);
        check_output($sformatf("%s busy", tag), 32'(busy), 32'd1);
        @(posedge clk); #1;
        check_output($sformatf("%s prestart", tag), 32'(txd), 32'd1);
        check_frame(1'b0, {1'b0, w}, 8, 1, exp_par, tag);
        check_output($sformatf("%s idle", tag), 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t       vecs [7];
        logic [7:0] bw [6];
        int         exp_cnt [5];
        int         base;
        int         lows;

        vecs[0] = '{8'h41, 1'b0, 1'b0};
        vecs[1] = '{8'h03, 1'b1, 1'b1};
        vecs[2] = '{8'h03, 1'b0, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h07, 1'b0, 1'b1};
        vecs[6] = '{8'h00, 1'b1, 1'b1};
        bw      = '{8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h33, 8'hC3};
        exp_cnt = '{1, 1, 2, 3, 4};

        rst       = 1'b1;
        tx_data   = 8'h00;
        tx_valid  = 1'b0;
        tx_data2  = 7'h00;
        tx_valid2 = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_output("reset txd", 32'(txd), 32'd1);
        check_output("reset tx_ready", 32'(tx_ready), 32'd1);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset fifo_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
`ifdef UART_TX_PARITY_EN
            parity_odd = vecs[i].par_odd;
`endif
            apply_stimulus(vecs[i].word, vecs[i].exp_par, $sformatf("vec%0d", i));
        end

        // Burst: five words fill the FIFO, a sixth is held until the first frame ends.
`ifdef UART_TX_PARITY_EN
        parity_odd = 1'b1;
`endif
        base = 0;
        @(negedge clk);
        tx_data  = bw[0];
        tx_valid = 1'b1;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    tx_data = bw[i];
                    @(posedge clk); #1;
                    if (i == 0) base = cyc;
                    check_output($sformatf("burst count%0d", i), 32'(fifo_count), 32'(exp_cnt[i]));
                end
                tx_data = bw[5];
                check_output("burst full ready", 32'(tx_ready), 32'd0);
                for (int t = 0; t < 400; t++) begin
                    @(negedge clk);
                    if (tx_ready) break;
                end
                @(posedge clk); #1;
                tx_valid = 1'b0;
                check_output("burst held accept cycle", 32'(cyc - base), 32'(2 + FRAME_CLKS));
                check_output("burst count after refill", 32'(fifo_count), 32'd4);
            end
            begin
                @(posedge clk);
                @(posedge clk); #1;
                check_output("burst prestart", 32'(txd), 32'd1);
                for (int k = 0; k < 6; k++)
                    check_frame(1'b0, {1'b0, bw[k]}, 8, 1, ~(^bw[k]), $sformatf("burst%0d", k));
                check_output("burst idle busy", 32'(busy), 32'd0);
                check_output("burst idle count", 32'(fifo_count), 32'd0);
            end
        join

        // Seven data bits, two stop bits on the second instance.
        @(negedge clk);
        tx_data2  = 7'h7F;
        tx_valid2 = 1'b1;
        @(posedge clk); #1;
        tx_valid2 = 1'b0;
        check_output("stop2 count", 32'(fifo_count2), 32'd1);
        @(posedge clk); #1;
        check_output("stop2 prestart", 32'(txd2), 32'd1);
        check_frame(1'b1, {2'b00, 7'h7F}, 7, 2, 1'b0, "stop2");
        check_output("stop2 idle", 32'(busy2), 32'd0);

        // Reset in the middle of a frame with a second word still queued.
        @(negedge clk);
        tx_data  = 8'h41;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_data = 8'h42;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check_output("midrst queued", 32'(fifo_count), 32'd1);
        repeat (34) @(posedge clk);
        #1;
        check_output("midrst bit2 low", 32'(txd), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check_output("midrst txd", 32'(txd), 32'd1);
        check_output("midrst count", 32'(fifo_count), 32'd0);
        check_output("midrst busy", 32'(busy), 32'd0);
        check_output("midrst ready", 32'(tx_ready), 32'd1);
        rst  = 1'b0;
        lows = 0;
        for (int t = 0; t < 150; t++) begin
            @(posedge clk); #1;
            if (txd !== 1'b1) lows++;
        end
        check_output("midrst no restart", 32'(lows), 32'd0);
        check_output("midrst still idle", 32'(busy), 32'd0);
        apply_stimulus(8'h5A, 1'b1, "postrst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: bench did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
